// File: rtl/stack_op_sequencer_if.sv
// Decode-side request/trap signals and operand-stack pop/push signals of the parametric-op sequencer.
// master = sequencer side, slave = decode/operand-stack side.
interface stack_op_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [7:0]       op;
    logic             busy;
    logic             done;
    logic [3:0]       trap;
    logic             stack_empty;
    logic [WIDTH-1:0] stack_top;
    logic             stack_pop;
    logic             stack_push;
    logic [WIDTH-1:0] stack_push_data;

    modport master (
        input  start, op, stack_empty, stack_top,
        output busy, done, trap, stack_pop, stack_push, stack_push_data
    );

    modport slave (
        output start, op, stack_empty, stack_top,
        input  busy, done, trap, stack_pop, stack_push, stack_push_data
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// Sequences WebAssembly drop/select against the operand stack: pops, condition test, result push.
// Latency: select done 4 cycles after start, drop done 2 cycles after start.
// Backpressure: start is only sampled in IDLE; requests while busy or trapped are dropped.
module stack_op_sequencer #(
    parameter int         WIDTH          = 64,
    parameter logic [3:0] TRAP_UNDERFLOW = 4'd1,
    parameter logic [3:0] TRAP_ILLEGAL   = 4'd2
) (
    input  logic                 clk,
    input  logic                 reset,
    stack_op_sequencer_if.master bus
);
    localparam logic [7:0] OP_DROP   = 8'h1A;
    localparam logic [7:0] OP_SELECT = 8'h1B;

    typedef enum logic [2:0] {
        IDLE,
        POP_COND,
        POP_V2,
        POP_V1,
        PUSH,
        FINISH,
        TRAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       trap_code;
    logic [3:0]       trap_nxt;
    logic             drop_flag;
    logic [WIDTH-1:0] cond;
    logic [WIDTH-1:0] v2;
    logic [WIDTH-1:0] v1;
    logic             have_entry;

    assign have_entry = !bus.stack_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            trap_code <= 4'd0;
        end else begin
            state     <= state_nxt;
            trap_code <= trap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        trap_nxt  = trap_code;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_SELECT) begin
                        state_nxt = POP_COND;
                    end else if (bus.op == OP_DROP) begin
                        state_nxt = POP_V1;
                    end else begin
                        state_nxt = TRAP;
                        trap_nxt  = TRAP_ILLEGAL;
                    end
                end
            end
            POP_COND, POP_V2, POP_V1: begin
                if (!have_entry) begin
                    state_nxt = TRAP;
                    trap_nxt  = TRAP_UNDERFLOW;
                end else if (state == POP_COND) begin
                    state_nxt = POP_V2;
                end else if (state == POP_V2) begin
                    state_nxt = POP_V1;
                end else begin
                    state_nxt = drop_flag ? FINISH : PUSH;
                end
            end
            PUSH, FINISH: state_nxt = IDLE;
            TRAP:         state_nxt = TRAP;
            default:      state_nxt = IDLE;
        endcase
    end

    // Operand capture: each pop state latches the entry it removes.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_flag <= 1'b0;
            cond      <= '0;
            v2        <= '0;
            v1        <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                drop_flag <= (bus.op == OP_DROP);
            end
            if (have_entry) begin
                if (state == POP_COND) cond <= bus.stack_top;
                if (state == POP_V2)   v2   <= bus.stack_top;
                if (state == POP_V1)   v1   <= bus.stack_top;
            end
        end
    end

    always_comb begin
        bus.busy            = (state != IDLE) && (state != TRAP);
        bus.done            = (state == PUSH) || (state == FINISH);
        bus.trap            = trap_code;
        bus.stack_pop       = 1'b0;
        bus.stack_push      = 1'b0;
        bus.stack_push_data = '0;
        case (state)
            POP_COND, POP_V2, POP_V1: bus.stack_pop = have_entry;
            PUSH: begin
                bus.stack_push      = 1'b1;
                // Only the i32 condition word matters; upper bits are ignored.
                bus.stack_push_data = (cond[31:0] != 32'd0) ? v1 : v2;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_stack_op_sequencer.sv
// Drives drop/select/illegal ops against a queue-modelled operand stack and checks the cycle timeline.
module tb_stack_op_sequencer;
    localparam int NC = 6;

    logic clk;
    logic reset;

    stack_op_sequencer_if #(.WIDTH(64)) bus ();

    stack_op_sequencer #(.WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] stk[$];
    logic [63:0] exp_stk[$];
    bit          e_busy [1:NC];
    bit          e_pop  [1:NC];
    bit          e_push [1:NC];
    bit          e_done [1:NC];
    logic [3:0]  e_trap [1:NC];
    logic [63:0] e_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        bus.stack_empty = (stk.size() == 0);
        bus.stack_top   = (stk.size() != 0) ? stk[stk.size()-1] : 64'd0;
    endtask

    task automatic set_stack3(input int n, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        stk.delete();
        if (n > 0) stk.push_back(a);
        if (n > 1) stk.push_back(b);
        if (n > 2) stk.push_back(c);
        refresh();
    endtask

    // Advance one edge, applying whatever pop/push the DUT showed in the cycle before it.
    task automatic edge_apply(input logic p, input logic q, input logic [63:0] d);
        logic [63:0] tmp;
        @(posedge clk);
        #1;
        if (p && stk.size() > 0) tmp = stk.pop_back();
        if (q) stk.push_back(d);
        refresh();
    endtask

    // Expected per-cycle outcome derived from the instruction semantics.
    task automatic model(input logic [7:0] opc);
        int n, need, pops, c;
        logic [63:0] cv, tmp;
        n = stk.size();
        for (int k = 1; k <= NC; k++) begin
            e_busy[k] = 0; e_pop[k] = 0; e_push[k] = 0; e_done[k] = 0; e_trap[k] = 4'd0;
        end
        e_data  = 64'd0;
        exp_stk = stk;
        if (opc == 8'h1B)      need = 3;
        else if (opc == 8'h1A) need = 1;
        else                   need = 0;
        if (need == 0) begin
            for (int k = 1; k <= NC; k++) e_trap[k] = 4'd2;
        end else begin
            pops = (n < need) ? n : need;
            for (int k = 1; k <= pops; k++) begin e_busy[k] = 1; e_pop[k] = 1; end
            for (int k = 0; k < pops; k++) tmp = exp_stk.pop_back();
            if (pops < need) begin
                e_busy[pops+1] = 1;
                for (int k = pops + 2; k <= NC; k++) e_trap[k] = 4'd1;
            end else begin
                c = pops + 1;
                e_busy[c] = 1;
                e_done[c] = 1;
                if (need == 3) begin
                    cv        = stk[n-1];
                    e_push[c] = 1;
                    e_data    = (cv[31:0] != 32'd0) ? stk[n-3] : stk[n-2];
                    exp_stk.push_back(e_data);
                end
            end
        end
    endtask

    task automatic run_op(input logic [7:0] opc, input string name);
        logic p, q;
        logic [63:0] d;
        model(opc);
        bus.start = 1'b1;
        bus.op    = opc;
        edge_apply(1'b0, 1'b0, 64'd0);
        bus.start = 1'b0;
        for (int k = 1; k <= NC; k++) begin
            @(negedge clk);
            chk($sformatf("%s_busy_c%0d", name, k), bus.busy, e_busy[k]);
            chk($sformatf("%s_pop_c%0d", name, k), bus.stack_pop, e_pop[k]);
            chk($sformatf("%s_push_c%0d", name, k), bus.stack_push, e_push[k]);
            chk($sformatf("%s_done_c%0d", name, k), bus.done, e_done[k]);
            chk($sformatf("%s_trap_c%0d", name, k), bus.trap, e_trap[k]);
            if (e_push[k]) chk($sformatf("%s_data", name), bus.stack_push_data, e_data);
            p = bus.stack_pop;
            q = bus.stack_push;
            d = bus.stack_push_data;
            edge_apply(p, q, d);
        end
        chk($sformatf("%s_stk_size", name), stk.size(), exp_stk.size());
        for (int i = 0; i < stk.size() && i < exp_stk.size(); i++)
            chk($sformatf("%s_stk%0d", name, i), stk[i], exp_stk[i]);
    endtask

    // Trap must be sticky against a fresh start, and cleared only by reset.
    task automatic recover(input logic [3:0] code, input string name);
        bus.start = 1'b1;
        bus.op    = 8'h1B;
        edge_apply(1'b0, 1'b0, 64'd0);
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("%s_sticky_trap", name), bus.trap, code);
            chk($sformatf("%s_sticky_busy", name), bus.busy, 1'b0);
            chk($sformatf("%s_sticky_pop", name), bus.stack_pop, 1'b0);
            chk($sformatf("%s_sticky_done", name), bus.done, 1'b0);
            edge_apply(1'b0, 1'b0, 64'd0);
        end
        reset = 1'b1;
        edge_apply(1'b0, 1'b0, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_rst_trap", name), bus.trap, 4'd0);
        chk($sformatf("%s_rst_busy", name), bus.busy, 1'b0);
        edge_apply(1'b0, 1'b0, 64'd0);
    endtask

    initial begin
        logic [63:0] r[3];
        logic [7:0]  ropc;
        int          depth, sel;
        logic        p;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 8'h00;
        stk.delete();
        refresh();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_trap", bus.trap, 4'd0);
        chk("reset_pop", bus.stack_pop, 1'b0);
        chk("reset_push", bus.stack_push, 1'b0);
        chk("reset_data", bus.stack_push_data, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        edge_apply(1'b0, 1'b0, 64'd0);

        set_stack3(3, 64'd5, 64'd7, 64'd1);
        run_op(8'h1B, "sel_true");
        chk("sel_true_result", stk[stk.size()-1], 64'd5);

        set_stack3(3, 64'd5, 64'd7, 64'h0000_0001_0000_0000);
        run_op(8'h1B, "sel_hi_cond");
        chk("sel_hi_cond_result", stk[stk.size()-1], 64'd7);

        set_stack3(1, 64'hAA, 64'd0, 64'd0);
        run_op(8'h1A, "drop");

        set_stack3(2, 64'd5, 64'd1, 64'd0);
        run_op(8'h1B, "sel_uflow");
        recover(4'd1, "sel_uflow");

        set_stack3(2, 64'd3, 64'd4, 64'd0);
        run_op(8'h20, "illegal");
        recover(4'd2, "illegal");

        set_stack3(0, 64'd0, 64'd0, 64'd0);
        run_op(8'h1A, "drop_empty");
        recover(4'd1, "drop_empty");

        // Reset arriving in the second cycle of a select.
        set_stack3(3, 64'd5, 64'd7, 64'd1);
        bus.start = 1'b1;
        bus.op    = 8'h1B;
        edge_apply(1'b0, 1'b0, 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("midrst_pop_c1", bus.stack_pop, 1'b1);
        edge_apply(1'b1, 1'b0, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        p = bus.stack_pop;
        chk("midrst_pop_c2", p, 1'b1);
        edge_apply(p, 1'b0, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_pop", bus.stack_pop, 1'b0);
        chk("midrst_push", bus.stack_push, 1'b0);
        chk("midrst_trap", bus.trap, 4'd0);
        chk("midrst_data", bus.stack_push_data, 64'd0);
        chk("midrst_stk_size", stk.size(), 1);
        edge_apply(1'b0, 1'b0, 64'd0);
        set_stack3(3, 64'd9, 64'd11, 64'd0);
        run_op(8'h1B, "after_rst");
        chk("after_rst_result", stk[stk.size()-1], 64'd11);

        for (int it = 0; it < 30; it++) begin
            depth = $urandom_range(0, 4);
            for (int i = 0; i < 3; i++) r[i] = {$urandom, $urandom};
            sel = $urandom_range(0, 2);
            if (sel == 0) r[2] = 64'd0;
            else if (sel == 1) r[2] = {$urandom | 32'd1, 32'd0};
            stk.delete();
            for (int i = 3; i < depth; i++) stk.push_back({$urandom, $urandom});
            for (int i = 0; i < 3 && i < depth; i++) stk.push_back(r[i]);
            refresh();
            sel = $urandom_range(0, 9);
            if (sel < 5)      ropc = 8'h1B;
            else if (sel < 8) ropc = 8'h1A;
            else begin
                ropc = 8'($urandom_range(0, 255));
                if (ropc == 8'h1A || ropc == 8'h1B) ropc = 8'hFF;
            end
            run_op(ropc, $sformatf("rnd%0d", it));
            if (e_trap[NC] != 4'd0) recover(e_trap[NC], $sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
